// File: rtl/s_mem_arbiter_pkg.sv
// rtl/s_mem_arbiter_pkg.sv - shared constants, state type and index helpers for the S-memory arbiter
package rc4_mem_pkg;

  localparam int N_REQ = 3;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam int REQ_INIT = 0;
  localparam int REQ_KSA  = 1;
  localparam int REQ_PRGA = 2;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    DRAIN
  } arb_state_t;

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [IW-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (oh[k]) idx = IW'(k);
    end
    return idx;
  endfunction

  // Successor index, wrapping from the last requester back to 0.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/s_mem_arbiter_if.sv
// rtl/s_mem_arbiter_if.sv - requester-side bundle between the RC4 phase FSMs and the arbiter
interface s_mem_arbiter_if;
  import rc4_mem_pkg::*;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    wren;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       rdata;
  logic [N_REQ-1:0]    rvalid;

  // Phase FSM side: raises requests and drives accesses, receives grant and read data.
  modport master (
    output req, addr, wdata, wren,
    input  gnt, rdata, rvalid
  );

  // Arbiter side.
  modport slave (
    input  req, addr, wdata, wren,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/s_mem_pick.sv
// rtl/s_mem_pick.sv - combinational rotating-priority picker over the request vector
module s_mem_pick
  import rc4_mem_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  // Scan from the start pointer upward, wrapping, and take the first request seen.
  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// rtl/s_mem_arbiter.sv - locked-grant arbiter sharing the single-port S-memory between RC4 phases
module s_mem_arbiter
  import rc4_mem_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  s_mem_arbiter_if.slave       bus,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_wren,
  input  logic [DW-1:0]        mem_q,
  output logic                 busy,
  output logic                 viol
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic             viol_q, viol_d;

  logic [IW-1:0]    pick_start;
  logic [N_REQ-1:0] pick_winner;
  logic             pick_valid;

  logic             owner_req;
  logic             access;
  logic             rd_issue;

  // Fixed priority is the rotating picker pinned to start at index 0.
  assign pick_start = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;

  s_mem_pick u_pick (
    .req    (bus.req),
    .start  (pick_start),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign owner_req = bus.req[owner_q];
  assign access    = (state_q == OWN) && owner_req;
  assign rd_issue  = access && !bus.wren[owner_q];

  // Next-state, grant bookkeeping and per-cycle RAM port mux.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          gnt_d   = pick_winner;
          owner_d = onehot_to_idx(pick_winner);
        end
      end
      OWN: begin
        if (owner_req) begin
          mem_addr  = bus.addr[owner_q*AW +: AW];
          mem_wdata = bus.wdata[owner_q*DW +: DW];
          // A write must never land while reset is asserted.
          mem_wren  = bus.wren[owner_q] && !reset;
        end else begin
          state_d = DRAIN;
          gnt_d   = '0;
          if (ROUND_ROBIN != 0) rr_ptr_d = next_idx(owner_q);
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // Reads answer one cycle later, on the owner's lane only.
    rvalid_d = rd_issue ? gnt_q : '0;
    // Any write attempt from a lane that does not hold the grant is latched.
    viol_d   = viol_q | (|(bus.wren & ~gnt_q));
  end

  // State, grant, pointer, read-valid and violation registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      viol_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      viol_q   <= viol_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = mem_q;
  assign busy       = (state_q != IDLE);
  assign viol       = viol_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb/tb_s_mem_arbiter.sv - directed bench for s_mem_arbiter in fixed-priority and rotating modes
module tb_s_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] addr = '0;
  logic [23:0] wdata = '0;
  logic [2:0]  wren = '0;
  bit          chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  s_mem_arbiter_if if_fp();
  s_mem_arbiter_if if_rr();
  assign if_fp.req = req;   assign if_rr.req = req;
  assign if_fp.addr = addr; assign if_rr.addr = addr;
  assign if_fp.wdata = wdata; assign if_rr.wdata = wdata;
  assign if_fp.wren = wren; assign if_rr.wren = wren;

  logic [7:0] ma_fp, mw_fp, q_fp, ma_rr, mw_rr, q_rr;
  logic       we_fp, we_rr, busy_fp, busy_rr, viol_fp, viol_rr;

  s_mem_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset(reset), .bus(if_fp),
    .mem_addr(ma_fp), .mem_wdata(mw_fp), .mem_wren(we_fp), .mem_q(q_fp),
    .busy(busy_fp), .viol(viol_fp)
  );

  s_mem_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset), .bus(if_rr),
    .mem_addr(ma_rr), .mem_wdata(mw_rr), .mem_wren(we_rr), .mem_q(q_rr),
    .busy(busy_rr), .viol(viol_rr)
  );

  // Write-first synchronous RAMs, preloaded with S[i] = i.
  logic [7:0] ram_fp [256];
  logic [7:0] ram_rr [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_fp[i] = 8'(i);
      ram_rr[i] = 8'(i);
    end
  end
  always @(posedge clk) begin
    if (we_fp) ram_fp[ma_fp] <= mw_fp;
    q_fp <= we_fp ? mw_fp : ram_fp[ma_fp];
    if (we_rr) ram_rr[ma_rr] <= mw_rr;
    q_rr <= we_rr ? mw_rr : ram_rr[ma_rr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model per mode: who owns the RAM, how many gnt-low cycles remain
  // before requests are looked at again, rotation pointer, pending read and a shadow RAM.
  int         m_own  [2];
  int         m_cool [2];
  int         m_ptr  [2];
  logic [2:0] m_pend [2];
  logic [7:0] m_rd   [2];
  bit         m_viol [2];
  logic [7:0] m_ram  [2][256];

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1; m_cool[m] = 0; m_ptr[m] = 0;
      m_pend[m] = '0; m_rd[m] = '0; m_viol[m] = 1'b0;
      for (int i = 0; i < 256; i++) m_ram[m][i] = 8'(i);
    end
  end

  task automatic model_cycle(input int m, input logic [2:0] g, input logic b, input logic [2:0] rv,
                             input logic [7:0] rd, input logic [7:0] ma, input logic [7:0] mw,
                             input logic we, input logic vl);
    string      t;
    logic [2:0] eg;
    bit         acc;
    int         o;
    t   = (m == 0) ? "fp" : "rr";
    o   = m_own[m];
    eg  = (o >= 0) ? 3'(1 << o) : 3'b000;
    acc = (o >= 0) && req[o];
    chk({t, "_gnt"}, 32'(g), 32'(eg));
    chk({t, "_busy"}, 32'(b), 32'((o >= 0) || (m_cool[m] > 0)));
    chk({t, "_rvalid"}, 32'(rv), 32'(m_pend[m]));
    if (m_pend[m] != 3'b000) chk({t, "_rdata"}, 32'(rd), 32'(m_rd[m]));
    chk({t, "_mem_wren"}, 32'(we), 32'(acc && wren[o] && !reset));
    if (acc) begin
      chk({t, "_mem_addr"}, 32'(ma), 32'(addr[o*8 +: 8]));
      chk({t, "_mem_wdata"}, 32'(mw), 32'(wdata[o*8 +: 8]));
    end else if (o < 0) begin
      chk({t, "_mem_addr_idle"}, 32'(ma), 32'd0);
      chk({t, "_mem_wdata_idle"}, 32'(mw), 32'd0);
    end
    chk({t, "_viol"}, 32'(vl), 32'(m_viol[m]));

    if (reset) begin
      m_own[m] = -1; m_cool[m] = 0; m_ptr[m] = 0; m_pend[m] = '0; m_viol[m] = 1'b0;
    end else begin
      m_pend[m] = '0;
      if (acc && !wren[o]) begin
        m_pend[m] = eg;
        m_rd[m]   = m_ram[m][addr[o*8 +: 8]];
      end
      if (acc && wren[o]) m_ram[m][addr[o*8 +: 8]] = wdata[o*8 +: 8];
      if ((wren & ~eg) != 3'b000) m_viol[m] = 1'b1;
      if (o >= 0) begin
        if (!req[o]) begin
          if (m == 1) m_ptr[m] = (o + 1) % 3;
          m_own[m]  = -1;
          m_cool[m] = 1;
        end
      end else if (m_cool[m] > 0) begin
        m_cool[m]--;
      end else begin
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (m_ptr[m] + k) % 3;
          if (m_own[m] < 0 && req[i]) m_own[m] = i;
        end
      end
    end
  endtask

  // Compare both DUTs against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      model_cycle(0, if_fp.gnt, busy_fp, if_fp.rvalid, if_fp.rdata, ma_fp, mw_fp, we_fp, viol_fp);
      model_cycle(1, if_rr.gnt, busy_rr, if_rr.rvalid, if_rr.rdata, ma_rr, mw_rr, we_rr, viol_rr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input bit r, input logic [7:0] a, input logic [7:0] d, input bit w);
    req[i] = r;
    addr[i*8 +: 8] = a;
    wdata[i*8 +: 8] = d;
    wren[i] = w;
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    // c0: KSA requests, reads 0x05 once granted
    reset = 1'b0;
    drv(1, 1, 8'h05, 8'h00, 0);
    #3 chk("c0_gnt", 32'(if_fp.gnt), 32'h0); chk("c0_busy", 32'(busy_fp), 32'h0);
    cyc(); // c1
    #3 chk("c1_gnt_fp", 32'(if_fp.gnt), 32'h2); chk("c1_gnt_rr", 32'(if_rr.gnt), 32'h2);
    chk("c1_busy", 32'(busy_fp), 32'h1);
    cyc(); // c2
    drv(1, 1, 8'h05, 8'hA7, 1);
    #3 chk("c2_rvalid", 32'(if_fp.rvalid), 32'h2); chk("c2_rdata", 32'(if_fp.rdata), 32'h05);
    cyc(); // c3
    drv(1, 1, 8'h05, 8'h00, 0);
    cyc(); // c4
    drv(1, 1, 8'h06, 8'h00, 0);
    #3 chk("c4_rvalid", 32'(if_fp.rvalid), 32'h2); chk("c4_rdata_raw", 32'(if_fp.rdata), 32'hA7);
    cyc(); // c5
    drv(1, 0, 8'h00, 8'h00, 0);
    #3 chk("c5_gnt", 32'(if_fp.gnt), 32'h2);
    cyc(); // c6
    #3 chk("c6_gnt", 32'(if_fp.gnt), 32'h0); chk("c6_busy", 32'(busy_fp), 32'h1);
    cyc(); // c7
    #3 chk("c7_busy", 32'(busy_fp), 32'h0);
    cyc(); // c8: simultaneous KSA and PRGA
    drv(1, 1, 8'h00, 8'h00, 0); drv(2, 1, 8'h00, 8'h00, 0);
    cyc(); // c9
    #3 chk("c9_gnt_fp", 32'(if_fp.gnt), 32'h2); chk("c9_gnt_rr", 32'(if_rr.gnt), 32'h4);
    cyc(); // c10
    drv(1, 0, 8'h00, 8'h00, 0);
    cyc(); // c11
    #3 chk("c11_gnt_fp", 32'(if_fp.gnt), 32'h0);
    cyc(); // c12
    #3 chk("c12_gnt_fp", 32'(if_fp.gnt), 32'h0);
    cyc(); // c13
    #3 chk("c13_gnt_fp", 32'(if_fp.gnt), 32'h4);
    cyc(); // c14
    cyc(); // c15
    drv(2, 0, 8'h00, 8'h00, 0);
    cyc(); // c16
    cyc(); // c17: all three request; owners release in turn after two reads
    drv(0, 1, 8'h30, 8'h00, 0); drv(1, 1, 8'h31, 8'h00, 0); drv(2, 1, 8'h32, 8'h00, 0);
    cyc(); // c18
    #3 chk("c18_gnt_rr", 32'(if_rr.gnt), 32'h1);
    cyc(); // c19
    cyc(); // c20
    drv(0, 0, 8'h30, 8'h00, 0);
    cyc(); // c21
    drv(0, 1, 8'h30, 8'h00, 0);
    #3 chk("c21_gnt_rr", 32'(if_rr.gnt), 32'h0);
    cyc(); // c22
    cyc(); // c23
    #3 chk("c23_gnt_rr", 32'(if_rr.gnt), 32'h2);
    cyc(); // c24
    cyc(); // c25
    drv(1, 0, 8'h31, 8'h00, 0);
    cyc(); // c26
    drv(1, 1, 8'h31, 8'h00, 0);
    #3 chk("c26_gnt_rr", 32'(if_rr.gnt), 32'h0);
    cyc(); // c27
    cyc(); // c28
    #3 chk("c28_gnt_rr", 32'(if_rr.gnt), 32'h4);
    cyc(); // c29
    cyc(); // c30
    drv(2, 0, 8'h32, 8'h00, 0);
    cyc(); // c31
    drv(2, 1, 8'h32, 8'h00, 0);
    #3 chk("c31_gnt_rr", 32'(if_rr.gnt), 32'h0);
    cyc(); // c32
    cyc(); // c33
    #3 chk("c33_gnt_rr", 32'(if_rr.gnt), 32'h1); chk("c33_gnt_fp", 32'(if_fp.gnt), 32'h1);
    cyc(); // c34
    req = '0;
    cyc(); // c35
    cyc(); // c36: init owns; PRGA attempts an unauthorised write
    drv(0, 1, 8'h10, 8'h00, 0);
    cyc(); // c37
    drv(2, 0, 8'h10, 8'h55, 1);
    #3 chk("c37_gnt", 32'(if_fp.gnt), 32'h1); chk("c37_mem_wren", 32'(we_fp), 32'h0);
    chk("c37_viol", 32'(viol_fp), 32'h0);
    cyc(); // c38
    drv(2, 0, 8'h00, 8'h00, 0);
    #3 chk("c38_viol_fp", 32'(viol_fp), 32'h1); chk("c38_viol_rr", 32'(viol_rr), 32'h1);
    chk("c38_rdata", 32'(if_fp.rdata), 32'h10);
    cyc(); // c39
    drv(0, 0, 8'h00, 8'h00, 0);
    #3 chk("c39_viol", 32'(viol_fp), 32'h1);
    cyc(); // c40
    cyc(); // c41
    drv(0, 1, 8'h20, 8'h00, 0);
    #3 chk("c41_ram10_fp", 32'(ram_fp[8'h10]), 32'h10); chk("c41_ram10_rr", 32'(ram_rr[8'h10]), 32'h10);
    cyc(); // c42
    cyc(); // c43: reset lands on an owner write
    drv(0, 1, 8'h20, 8'h99, 1);
    reset = 1'b1;
    #3 chk("c43_mem_wren", 32'(we_fp), 32'h0); chk("c43_rvalid", 32'(if_fp.rvalid), 32'h1);
    chk("c43_viol", 32'(viol_fp), 32'h1);
    cyc(); // c44
    reset = 1'b0;
    drv(0, 0, 8'h00, 8'h00, 0);
    #3 chk("c44_gnt", 32'(if_fp.gnt), 32'h0); chk("c44_rvalid", 32'(if_fp.rvalid), 32'h0);
    chk("c44_busy", 32'(busy_rr), 32'h0); chk("c44_viol", 32'(viol_fp), 32'h0);
    chk("c44_ram20", 32'(ram_fp[8'h20]), 32'h20);
    cyc();
    cyc();
    #3 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
